// File: rtl/system_reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its environment:
// PLL lock/restart in, staged resets and status out.
interface system_reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  pll_locked;
  logic                  restart;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  delay_done;
  logic                  busy;
  logic [3:0]            stage_idx;

  modport master (
    output pll_locked, restart,
    input  stage_rst_n, delay_done, busy, stage_idx
  );

  modport slave (
    input  pll_locked, restart,
    output stage_rst_n, delay_done, busy, stage_idx
  );
endinterface

// File: rtl/system_reset_sequencer.sv
// Power-on/reset sequencer: qualifies PLL lock, then releases NUM_STAGES
// active-low resets in order, STAGE_DELAY cycles apart.
module system_reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 2500000,
  parameter int LOCK_FILTER = 16,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  system_reset_sequencer_if.slave   sif
);
  typedef enum logic [1:0] {WAIT_LOCK, FILTER, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] DLY_M1  = CNT_WIDTH'(STAGE_DELAY - 1);
  localparam logic [8:0]           FILT_M1 = 9'(LOCK_FILTER - 1);
  localparam logic [3:0]           LAST    = 4'(NUM_STAGES - 1);

  state_t                state_q, state_d;
  logic [8:0]            filt_q, filt_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [NUM_STAGES-1:0] srst_q, srst_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  lost;

  // Lock loss outranks both restart and a coinciding stage release.
  assign lost = !sif.pll_locked && (state_q == RUN || state_q == DONE);

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    srst_d  = srst_q;
    done_d  = done_q;
    if (lost) begin
      state_d = WAIT_LOCK;
      filt_d  = '0;
      cnt_d   = '0;
      idx_d   = '0;
      srst_d  = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          srst_d = '0;
          done_d = 1'b0;
          if (sif.pll_locked) begin
            // A single-cycle filter is already satisfied by this sample.
            if (LOCK_FILTER == 1) begin
              state_d = RUN;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = FILTER;
              filt_d  = 9'd1;
            end
          end
        end
        FILTER: begin
          if (!sif.pll_locked) begin
            state_d = WAIT_LOCK;
            filt_d  = '0;
          end else if (filt_q >= FILT_M1) begin
            state_d = RUN;
            filt_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            filt_d = filt_q + 9'd1;
          end
        end
        RUN: begin
          if (cnt_q == DLY_M1) begin
            cnt_d = '0;
            for (int k = 0; k < NUM_STAGES; k++)
              if (4'(k) == idx_q) srst_d[k] = 1'b1;
            if (idx_q == LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          if (sif.restart) begin
            state_d = FILTER;
            filt_d  = '0;
            srst_d  = '0;
            done_d  = 1'b0;
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
    busy_d = (state_d == FILTER) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      srst_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      srst_q  <= srst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign sif.stage_rst_n = srst_q;
  assign sif.delay_done  = done_q;
  assign sif.busy        = busy_q;
  assign sif.stage_idx   = idx_q;
endmodule

// File: tb/tb_system_reset_sequencer.sv
// Two sequencer configurations (nominal 3/5/4 and boundary 4/1/1) driven by
// shared stimulus and checked every cycle against a progress-count model.
module tb_system_reset_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, pll = 1'b1, restart = 1'b0, probe = 1'b0;
  int   phase = 0;
  int   tests = 0, fails = 0;
  int   edge_no = 0;
  // n = edges of progress since qualification began (-1: waiting for lock)
  int   n [2] = '{-1, -1};

  localparam int NSA [2] = '{3, 4};
  localparam int SDA [2] = '{5, 1};
  localparam int LFA [2] = '{4, 1};

  always #5 clk = ~clk;

  system_reset_sequencer_if #(.NUM_STAGES(3)) sif0 ();
  system_reset_sequencer_if #(.NUM_STAGES(4)) sif1 ();
  assign sif0.pll_locked = pll;
  assign sif0.restart    = restart;
  assign sif1.pll_locked = pll;
  assign sif1.restart    = restart;

  system_reset_sequencer #(.NUM_STAGES(3), .STAGE_DELAY(5), .LOCK_FILTER(4), .CNT_WIDTH(8))
    dut0 (.clk(clk), .rst_n(rst_n), .sif(sif0));
  system_reset_sequencer #(.NUM_STAGES(4), .STAGE_DELAY(1), .LOCK_FILTER(1), .CNT_WIDTH(8))
    dut1 (.clk(clk), .rst_n(rst_n), .sif(sif1));

  function automatic int rel(int i, int nn);
    int r;
    if (nn < LFA[i]) return 0;
    r = (nn - LFA[i]) / SDA[i];
    return (r > NSA[i]) ? NSA[i] : r;
  endfunction

  function automatic int nxt(int i, int nn, logic lk, logic rs);
    if (nn < 0) return lk ? 1 : -1;
    if (!lk) return -1;
    if (rel(i, nn) == NSA[i]) return rs ? 0 : nn;
    return nn + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n[0] <= -1; n[1] <= -1; edge_no <= 0;
    end else begin
      n[0] <= nxt(0, n[0], pll, restart);
      n[1] <= nxt(1, n[1], pll, restart);
      edge_no <= edge_no + 1;
    end
  end

  function automatic logic [15:0] act_stage(int i);
    return (i == 0) ? 16'(sif0.stage_rst_n) : 16'(sif1.stage_rst_n);
  endfunction
  function automatic logic act_done(int i);
    return (i == 0) ? sif0.delay_done : sif1.delay_done;
  endfunction
  function automatic logic act_busy(int i);
    return (i == 0) ? sif0.busy : sif1.busy;
  endfunction
  function automatic logic [3:0] act_idx(int i);
    return (i == 0) ? sif0.stage_idx : sif1.stage_idx;
  endfunction

  task automatic lit(string nm, int i, logic [15:0] es, logic ed, logic eb);
    tests++;
    if (act_stage(i) !== es || act_done(i) !== ed || act_busy(i) !== eb) begin
      fails++;
      $display("FAIL %s dut%0d edge %0d: got stage=%h done=%b busy=%b, want stage=%h done=%b busy=%b",
               nm, i, edge_no, act_stage(i), act_done(i), act_busy(i), es, ed, eb);
    end
  endtask

  always begin
    @(negedge clk or posedge probe);
    for (int i = 0; i < 2; i++) begin
      int r; logic dn; logic [15:0] es; logic eb; logic [3:0] ei;
      r  = rel(i, n[i]);
      dn = (r == NSA[i]);
      es = 16'((1 << r) - 1);
      eb = (n[i] >= 0) && !dn;
      ei = (n[i] >= LFA[i] && !dn) ? 4'(r) : 4'd0;
      tests++;
      if (act_stage(i) !== es || act_done(i) !== dn || act_busy(i) !== eb || act_idx(i) !== ei) begin
        fails++;
        $display("FAIL model_cmp dut%0d edge %0d: got stage=%h done=%b busy=%b idx=%0d, want stage=%h done=%b busy=%b idx=%0d",
                 i, edge_no, act_stage(i), act_done(i), act_busy(i), act_idx(i), es, dn, eb, ei);
      end
    end
    if (probe) begin
      lit("async_rst", 0, 16'h0, 1'b0, 1'b0);
      lit("async_rst", 1, 16'h0, 1'b0, 1'b0);
    end else if (phase == 0 && !rst_n) begin
      lit("reset_state", 0, 16'h0, 1'b0, 1'b0);
      lit("reset_state", 1, 16'h0, 1'b0, 1'b0);
    end else if (phase == 1) begin
      case (edge_no)
        1:  lit("bnd_e1",      1, 16'h0, 1'b0, 1'b1);
        2:  lit("bnd_e2",      1, 16'h1, 1'b0, 1'b1);
        5:  lit("bnd_e5",      1, 16'hf, 1'b1, 1'b0);
        8:  lit("nom_e8",      0, 16'h0, 1'b0, 1'b1);
        9:  lit("nom_e9",      0, 16'h1, 1'b0, 1'b1);
        14: lit("nom_e14",     0, 16'h3, 1'b0, 1'b1);
        19: lit("nom_e19",     0, 16'h7, 1'b1, 1'b0);
        25: lit("restart_e25", 0, 16'h0, 1'b0, 1'b1);
        33: lit("restart_e33", 0, 16'h0, 1'b0, 1'b1);
        34: lit("restart_e34", 0, 16'h1, 1'b0, 1'b1);
        40: lit("lockloss_e40", 0, 16'h0, 1'b0, 1'b0);
        48: lit("relock_e48",  0, 16'h0, 1'b0, 1'b1);
        49: lit("relock_e49",  0, 16'h1, 1'b0, 1'b1);
        54: lit("relock_e54",  0, 16'h3, 1'b0, 1'b1);
        default: ;
      endcase
    end else if (phase == 2) begin
      case (edge_no)
        5:  lit("replay_bnd_e5", 1, 16'hf, 1'b1, 1'b0);
        9:  lit("replay_e9",     0, 16'h1, 1'b0, 1'b1);
        19: lit("replay_e19",    0, 16'h7, 1'b1, 1'b0);
        default: ;
      endcase
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    phase = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      case (edge_no)
        11: restart = 1'b1;
        12: restart = 1'b0;
        24: restart = 1'b1;
        25: restart = 1'b0;
        39: pll = 1'b0;
        40: pll = 1'b1;
        default: ;
      endcase
      if (edge_no == 54) break;
    end
    #2 rst_n = 1'b0;
    #1 probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
    phase = 2;
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    phase = 3;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      pll     = ($urandom_range(0, 99) < 97);
      restart = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
